// File: rtl/nrzi_rx_decoder_if.sv
//============================================================================
// Module   : nrzi_rx_decoder_if
// Brief    : Line-side sample inputs and byte/framing outputs of the
//            NRZI receive decoder, grouped as one bundle.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

interface nrzi_rx_decoder_if;
   logic       checkData;
   logic       dPlus;
   logic       dMinus;
   logic [7:0] rxData;
   logic       rxValid;
   logic       rxActive;
   logic       rxEop;
   logic       rxError;

   // Line driver / packet layer side
   modport master (
      output checkData, dPlus, dMinus,
      input  rxData, rxValid, rxActive, rxEop, rxError
   );

   // Decoder side
   modport slave (
      input  checkData, dPlus, dMinus,
      output rxData, rxValid, rxActive, rxEop, rxError
   );
endinterface

`default_nettype wire

// File: rtl/nrzi_rx_decoder.sv
//============================================================================
// Module   : nrzi_rx_decoder
// Brief    : USB full-speed receive path: NRZI decode, SYNC detection,
//            bit-stuff removal, LSB-first byte assembly and EOP detection.
//            Optional macro NRZI_RX_DRIBBLE_EN: when defined, a partial
//            byte at SE0 is dropped silently instead of flagging an error.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module nrzi_rx_decoder #(
   parameter int SYNC_MIN_ZEROS = 3,
   parameter int STUFF_LIMIT    = 6
) (
   input wire          useClk,
   input wire          resetN,
   nrzi_rx_decoder_if.slave bus
);

   localparam int              c_ONES_W   = $clog2(STUFF_LIMIT + 1);
   localparam logic [2:0]      c_SYNC_MIN = 3'(SYNC_MIN_ZEROS);
   localparam logic [c_ONES_W-1:0] c_STUFF = c_ONES_W'(STUFF_LIMIT);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SYNC      = 3'd1,
      S_DATA      = 3'd2,
      S_EOP       = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_t;

   state_t                r_state,     w_nxt_state;
   logic                  r_prev_j,    w_nxt_prev_j;
   logic [2:0]            r_zero_cnt,  w_nxt_zero_cnt;
   logic [2:0]            r_bit_cnt,   w_nxt_bit_cnt;
   logic [c_ONES_W-1:0]   r_ones_cnt,  w_nxt_ones_cnt;
   logic [1:0]            r_se_cnt,    w_nxt_se_cnt;
   logic [7:0]            r_shreg,     w_nxt_shreg;
   logic [7:0]            r_rx_data,   w_nxt_rx_data;
   logic                  r_rx_valid,  w_nxt_rx_valid;
   logic                  r_rx_active, w_nxt_rx_active;
   logic                  r_rx_eop,    w_nxt_rx_eop;
   logic                  r_rx_error,  w_nxt_rx_error;

   wire w_is_j  =  bus.dPlus & ~bus.dMinus;
   wire w_is_k  = ~bus.dPlus &  bus.dMinus;
   wire w_se0   = ~bus.dPlus & ~bus.dMinus;
   wire w_se1   =  bus.dPlus &  bus.dMinus;
   wire w_is_jk = w_is_j | w_is_k;
   // NRZI: no transition decodes as 1, a transition as 0
   wire w_bit   = (w_is_j == r_prev_j);

   // State and output registers; reset abandons any packet without pulses
   always_ff @(posedge useClk) begin
      if (!resetN) begin
         r_state     <= S_IDLE;
         r_prev_j    <= 1'b1;
         r_zero_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_ones_cnt  <= '0;
         r_se_cnt    <= '0;
         r_shreg     <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_rx_active <= 1'b0;
         r_rx_eop    <= 1'b0;
         r_rx_error  <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_prev_j    <= w_nxt_prev_j;
         r_zero_cnt  <= w_nxt_zero_cnt;
         r_bit_cnt   <= w_nxt_bit_cnt;
         r_ones_cnt  <= w_nxt_ones_cnt;
         r_se_cnt    <= w_nxt_se_cnt;
         r_shreg     <= w_nxt_shreg;
         r_rx_data   <= w_nxt_rx_data;
         r_rx_valid  <= w_nxt_rx_valid;
         r_rx_active <= w_nxt_rx_active;
         r_rx_eop    <= w_nxt_rx_eop;
         r_rx_error  <= w_nxt_rx_error;
      end
   end

   // Next-state and output decode; only strobe cycles advance, pulses self-clear
   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_prev_j    = r_prev_j;
      w_nxt_zero_cnt  = r_zero_cnt;
      w_nxt_bit_cnt   = r_bit_cnt;
      w_nxt_ones_cnt  = r_ones_cnt;
      w_nxt_se_cnt    = r_se_cnt;
      w_nxt_shreg     = r_shreg;
      w_nxt_rx_data   = r_rx_data;
      w_nxt_rx_valid  = 1'b0;
      w_nxt_rx_active = r_rx_active;
      w_nxt_rx_eop    = 1'b0;
      w_nxt_rx_error  = 1'b0;

      if (bus.checkData) begin
         if (w_is_jk) begin
            w_nxt_prev_j = w_is_j;
         end

         unique case (r_state)
            S_IDLE: begin
               if (w_is_k && r_prev_j) begin
                  w_nxt_zero_cnt = 3'd1;
                  w_nxt_state    = S_SYNC;
               end
            end

            S_SYNC: begin
               if (!w_is_jk) begin
                  w_nxt_state = S_IDLE;
               end else if (!w_bit) begin
                  if (r_zero_cnt != 3'd7) begin
                     w_nxt_zero_cnt = r_zero_cnt + 3'd1;
                  end
               end else if (r_zero_cnt >= c_SYNC_MIN) begin
                  w_nxt_state     = S_DATA;
                  w_nxt_rx_active = 1'b1;
                  w_nxt_bit_cnt   = '0;
                  w_nxt_ones_cnt  = '0;
               end else begin
                  w_nxt_state = S_IDLE;
               end
            end

            S_DATA: begin
               if (w_se0) begin
                  // A pending stuff bit at SE0 is legal; only a partial byte matters
                  w_nxt_se_cnt = 2'd1;
`ifdef NRZI_RX_DRIBBLE_EN
                  w_nxt_state  = S_EOP;
`else
                  if (r_bit_cnt != 3'd0) begin
                     w_nxt_rx_error  = 1'b1;
                     w_nxt_rx_active = 1'b0;
                     w_nxt_state     = S_WAIT_IDLE;
                  end else begin
                     w_nxt_state = S_EOP;
                  end
`endif
               end else if (w_se1) begin
                  w_nxt_rx_error  = 1'b1;
                  w_nxt_rx_active = 1'b0;
                  w_nxt_state     = S_WAIT_IDLE;
               end else if (r_ones_cnt == c_STUFF) begin
                  if (!w_bit) begin
                     w_nxt_ones_cnt = '0;
                  end else begin
                     w_nxt_rx_error  = 1'b1;
                     w_nxt_rx_active = 1'b0;
                     w_nxt_state     = S_WAIT_IDLE;
                  end
               end else begin
                  // Right shift so the first received bit lands in bit 0
                  w_nxt_shreg    = {w_bit, r_shreg[7:1]};
                  w_nxt_bit_cnt  = r_bit_cnt + 3'd1;
                  w_nxt_ones_cnt = w_bit ? r_ones_cnt + 1'b1 : '0;
                  if (r_bit_cnt == 3'd7) begin
                     w_nxt_rx_data  = {w_bit, r_shreg[7:1]};
                     w_nxt_rx_valid = 1'b1;
                  end
               end
            end

            S_EOP: begin
               if (w_se0) begin
                  w_nxt_se_cnt = r_se_cnt + 2'd1;
                  if (r_se_cnt == 2'd2) begin
                     w_nxt_rx_error  = 1'b1;
                     w_nxt_rx_active = 1'b0;
                     w_nxt_state     = S_WAIT_IDLE;
                  end
               end else if (w_is_j && (r_se_cnt >= 2'd2)) begin
                  w_nxt_rx_eop    = 1'b1;
                  w_nxt_rx_active = 1'b0;
                  w_nxt_state     = S_IDLE;
               end else begin
                  w_nxt_rx_error  = 1'b1;
                  w_nxt_rx_active = 1'b0;
                  w_nxt_state     = S_WAIT_IDLE;
               end
            end

            S_WAIT_IDLE: begin
               if (w_is_j) begin
                  w_nxt_state = S_IDLE;
               end
            end

            default: begin
               w_nxt_state = S_IDLE;
            end
         endcase
      end
   end

   assign bus.rxData   = r_rx_data;
   assign bus.rxValid  = r_rx_valid;
   assign bus.rxActive = r_rx_active;
   assign bus.rxEop    = r_rx_eop;
   assign bus.rxError  = r_rx_error;

endmodule

`default_nettype wire

// File: tb/tb_nrzi_rx_decoder.sv
//============================================================================
// Module   : tb_nrzi_rx_decoder
// Brief    : Self-checking bench for nrzi_rx_decoder. Packets are built as
//            bytes, serialised LSB-first with stuffing, NRZI-encoded onto
//            the line, and the decoder's pulses are compared with the byte
//            list and framing outcome each packet is expected to produce.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_nrzi_rx_decoder;

   localparam logic [1:0] c_J   = 2'b10;
   localparam logic [1:0] c_K   = 2'b01;
   localparam logic [1:0] c_SE0 = 2'b00;
   localparam logic [1:0] c_SE1 = 2'b11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nrzi_rx_decoder_if bus ();

   nrzi_rx_decoder dut (
      .useClk (clk),
      .resetN (rst_n),
      .bus    (bus)
   );

   int errors = 0;
   int checks = 0;

   // Pulse monitor, sampled on the falling edge
   logic [7:0] vq[$];
   int eop_cnt  = 0;
   int err_cnt  = 0;
   int excl_cnt = 0;

   always @(negedge clk) begin
      if (bus.rxValid) vq.push_back(bus.rxData);
      if (bus.rxEop) eop_cnt++;
      if (bus.rxError) err_cnt++;
      if (bus.rxValid && (bus.rxEop || bus.rxError)) excl_cnt++;
   end

   // Packet description and expected outcome
   logic [7:0] pkt_bytes[$];
   logic [7:0] exp_bytes[$];
   int         extra_bits = 0;
   logic [7:0] extra_val  = '0;
   logic [1:0] tb_prev    = c_J;
   int v_base, e_base, r_base, x_base;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // One strobed line symbol followed by a short random gap of junk lines
   task automatic sym(input logic [1:0] l);
      int gap;
      @(negedge clk);
      bus.dPlus     = l[1];
      bus.dMinus    = l[0];
      bus.checkData = 1'b1;
      @(negedge clk);
      bus.checkData = 1'b0;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
         bus.dPlus  = 1'($urandom);
         bus.dMinus = 1'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic send_bit(input logic b);
      if (!b) tb_prev = (tb_prev == c_J) ? c_K : c_J;
      sym(tb_prev);
   endtask

   task automatic send_sync(input int nzeros);
      for (int i = 0; i < nzeros; i++) send_bit(1'b0);
      send_bit(1'b1);
   endtask

   // Bytes LSB-first plus optional trailing partial bits, stuffed after six ones
   task automatic send_data(input bit bad_stuff);
      int ones  = 0;
      int nfull = pkt_bytes.size() * 8;
      int total = nfull + extra_bits;
      logic b;
      for (int i = 0; i < total; i++) begin
         if (i < nfull) b = pkt_bytes[i / 8][i % 8];
         else           b = extra_val[i - nfull];
         send_bit(b);
         ones = b ? ones + 1 : 0;
         if (ones == 6) begin
            if (bad_stuff) begin
               send_bit(1'b1);
               return;
            end
            send_bit(1'b0);
            ones = 0;
         end
      end
   endtask

   task automatic send_eop(input int nse0);
      for (int i = 0; i < nse0; i++) sym(c_SE0);
      sym(c_J);
      tb_prev = c_J;
   endtask

   task automatic recover_idle();
      sym(c_J);
      sym(c_J);
      tb_prev = c_J;
   endtask

   task automatic begin_pkt();
      v_base = vq.size();
      e_base = eop_cnt;
      r_base = err_cnt;
      x_base = excl_cnt;
      pkt_bytes.delete();
      exp_bytes.delete();
      extra_bits = 0;
   endtask

   task automatic finish_pkt(input string tag, input int exp_eop, input int exp_err);
      int n;
      repeat (3) @(negedge clk);
      n = vq.size() - v_base;
      check({tag, ".nvalid"}, n, exp_bytes.size());
      for (int i = 0; i < exp_bytes.size() && i < n; i++)
         check($sformatf("%s.byte%0d", tag, i), vq[v_base + i], exp_bytes[i]);
      check({tag, ".eop"}, eop_cnt - e_base, exp_eop);
      check({tag, ".err"}, err_cnt - r_base, exp_err);
      check({tag, ".excl"}, excl_cnt - x_base, 0);
      check({tag, ".active_end"}, bus.rxActive, 0);
   endtask

   // Clean packet: expected bytes are exactly the transmitted bytes
   task automatic clean_pkt(input string tag, input int nzeros);
      foreach (pkt_bytes[i]) exp_bytes.push_back(pkt_bytes[i]);
      send_sync(nzeros);
      check({tag, ".active_sync"}, bus.rxActive, 1);
      send_data(1'b0);
      send_eop(2);
      finish_pkt(tag, 1, 0);
      if (exp_bytes.size() > 0)
         check({tag, ".hold"}, bus.rxData, exp_bytes[exp_bytes.size() - 1]);
   endtask

   initial begin
      bus.checkData = 1'b0;
      bus.dPlus     = 1'b1;
      bus.dMinus    = 1'b0;

      // Reset held for three cycles with a busy line
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.dPlus     = 1'($urandom);
         bus.dMinus    = 1'($urandom);
         bus.checkData = 1'($urandom);
      end
      @(negedge clk);
      check("rst.rxData", bus.rxData, 8'h00);
      check("rst.rxValid", bus.rxValid, 0);
      check("rst.rxActive", bus.rxActive, 0);
      check("rst.rxEop", bus.rxEop, 0);
      check("rst.rxError", bus.rxError, 0);
      bus.checkData = 1'b0;
      bus.dPlus     = 1'b1;
      bus.dMinus    = 1'b0;
      rst_n = 1'b1;
      tb_prev = c_J;
      @(negedge clk);

      // Full SYNC and one byte
      begin_pkt();
      pkt_bytes.push_back(8'hA5);
      clean_pkt("a5", 7);

      // Stuffed run of ones
      begin_pkt();
      pkt_bytes.push_back(8'hFF);
      pkt_bytes.push_back(8'h00);
      clean_pkt("ff00", 7);

      // Stuff bit violated: error, no byte
      begin_pkt();
      pkt_bytes.push_back(8'hFF);
      pkt_bytes.push_back(8'h00);
      send_sync(7);
      send_data(1'b1);
      check("badstuff.active", bus.rxActive, 0);
      recover_idle();
      finish_pkt("badstuff", 0, 1);

      begin_pkt();
      pkt_bytes.push_back(8'h3C);
      clean_pkt("3c", 7);

      // Truncated SYNC still accepted
      begin_pkt();
      pkt_bytes.push_back(8'h5A);
      clean_pkt("trunc5a", 4);

      // Too-short SYNC returns to idle silently
      begin_pkt();
      send_sync(2);
      check("shortsync.active", bus.rxActive, 0);
      finish_pkt("shortsync", 0, 0);

      // SE0 after a partial second byte
      begin_pkt();
      pkt_bytes.push_back(8'($urandom));
      exp_bytes.push_back(pkt_bytes[0]);
      extra_bits = 4;
      extra_val  = 8'($urandom);
      send_sync(7);
      send_data(1'b0);
      send_eop(2);
`ifdef NRZI_RX_DRIBBLE_EN
      finish_pkt("partial", 1, 0);
`else
      finish_pkt("partial", 0, 1);
`endif

      // Over-long SE0
      begin_pkt();
      pkt_bytes.push_back(8'($urandom));
      exp_bytes.push_back(pkt_bytes[0]);
      send_sync(7);
      send_data(1'b0);
      send_eop(3);
      finish_pkt("se0x3", 0, 1);

      // SE1 after a complete byte
      begin_pkt();
      pkt_bytes.push_back(8'($urandom));
      exp_bytes.push_back(pkt_bytes[0]);
      send_sync(7);
      send_data(1'b0);
      sym(c_SE1);
      recover_idle();
      finish_pkt("se1", 0, 1);

      // Reset mid-byte, then a fresh packet
      begin_pkt();
      send_sync(7);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom));
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst.active", bus.rxActive, 0);
      check("midrst.data", bus.rxData, 8'h00);
      rst_n = 1'b1;
      tb_prev = c_J;
      bus.dPlus  = 1'b1;
      bus.dMinus = 1'b0;
      pkt_bytes.push_back(8'hC3);
      clean_pkt("c3", 7);

      // Random clean packets
      for (int p = 0; p < 8; p++) begin
         int len;
         begin_pkt();
         len = $urandom_range(1, 4);
         for (int i = 0; i < len; i++) pkt_bytes.push_back(8'($urandom));
         clean_pkt($sformatf("rnd%0d", p), $urandom_range(3, 7));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
